// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: MEM-stage FSM encoding and data-memory defaults.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT      = 32'h0000_0000;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts REQ-state cycles; expired flags the last cycle an ack may still arrive.
module mem_timeout_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for a req/ack data memory: stalls the pipeline, bubbles MEM/WB,
// and records bus errors. Define MEM_TIMEOUT_EN to compile in the ack timeout.
module mem_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = 8,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [31:0] aluIn,
  input  logic [31:0] rd2In,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] rdataOut,
  output logic        stall,
  output logic        memWbBubble,
  output logic        busErr,
  output logic [31:0] errAddr
);

  memState_t   state, stateNext;
  logic        reqNext, weNext, busErrNext;
  logic [31:0] addrNext, wdataNext, rdataNext, errAddrNext;
  logic        acc, timedOut;

  assign acc = memReadIn | memWriteIn;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_cnt #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .en     (state == REQ),
    .expired(timedOut)
  );
`else
  logic unusedCfg;
  assign unusedCfg = (TIMEOUT_CYCLES != 0) ^ (CNT_W != 0);
  assign timedOut  = 1'b0;
`endif

  always_comb begin
    stateNext   = state;
    reqNext     = dmem_req;
    weNext      = dmem_we;
    addrNext    = dmem_addr;
    wdataNext   = dmem_wdata;
    rdataNext   = rdataOut;
    busErrNext  = busErr;
    errAddrNext = errAddr;
    unique case (state)
      IDLE: begin
        if (memReadIn && memWriteIn) begin
          if (!busErr) begin
            busErrNext  = 1'b1;
            errAddrNext = aluIn;
          end
          rdataNext = ERR_RDATA;
          stateNext = DONE;
        end else if (acc) begin
          addrNext  = aluIn;
          wdataNext = rd2In;
          weNext    = memWriteIn;
          reqNext   = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        // ack has priority over a timeout landing in the same cycle
        if (dmem_ack) begin
          reqNext = 1'b0;
          if (!dmem_we) rdataNext = dmem_rdata;
          stateNext = DONE;
        end else if (timedOut) begin
          reqNext   = 1'b0;
          rdataNext = ERR_RDATA;
          if (!busErr) begin
            busErrNext  = 1'b1;
            errAddrNext = dmem_addr;
          end
          stateNext = DONE;
        end
      end
      DONE: stateNext = IDLE;
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdataOut   <= '0;
      busErr     <= 1'b0;
      errAddr    <= '0;
    end else begin
      state      <= stateNext;
      dmem_req   <= reqNext;
      dmem_we    <= weNext;
      dmem_addr  <= addrNext;
      dmem_wdata <= wdataNext;
      rdataOut   <= rdataNext;
      busErr     <= busErrNext;
      errAddr    <= errAddrNext;
    end
  end

  assign stall       = ((state == IDLE) && acc) || (state == REQ);
  assign memWbBubble = stall;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl against a transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int unsigned TMO     = 4;
  localparam logic [31:0] ERR_VAL = 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memReadIn = 1'b0, memWriteIn = 1'b0;
  logic [31:0] aluIn = '0, rd2In = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] rdataOut;
  logic        stall, memWbBubble, busErr;
  logic [31:0] errAddr;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (8),
    .ERR_RDATA     (ERR_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memReadIn  (memReadIn),
    .memWriteIn (memWriteIn),
    .aluIn      (aluIn),
    .rd2In      (rd2In),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .rdataOut   (rdataOut),
    .stall      (stall),
    .memWbBubble(memWbBubble),
    .busErr     (busErr),
    .errAddr    (errAddr)
  );

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  // reference model state
  logic [31:0] mRdata   = '0;
  logic        mBusErr  = 1'b0;
  logic [31:0] mErrAddr = '0;
  bit          inDone   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b0;
    memReadIn = 1'b0; memWriteIn = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req",     {31'd0, dmem_req}, 32'd0);
    check("rst_we",      {31'd0, dmem_we},  32'd0);
    check("rst_addr",    dmem_addr,  32'd0);
    check("rst_wdata",   dmem_wdata, 32'd0);
    check("rst_rdata",   rdataOut,   32'd0);
    check("rst_stall",   {31'd0, stall},  32'd0);
    check("rst_busErr",  {31'd0, busErr}, 32'd0);
    check("rst_errAddr", errAddr,    32'd0);
    rst = 1'b1;
    mRdata = '0; mBusErr = 1'b0; mErrAddr = '0; inDone = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    if (n == 0) return;
    memReadIn = 1'b0; memWriteIn = 1'b0; dmem_ack = 1'b0;
    if (inDone) begin
      @(negedge clk);
      inDone = 1'b0;
    end
    repeat (n - 1) @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  // One MEM-stage instruction. Memory acks on REQ cycle waits+1.
  task automatic doAccess(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int unsigned waits,
                          input logic [31:0] rdata);
    bit          illegal, tmo, finished;
    int unsigned expStall, expReq, stallCnt, reqCnt, badReq, badBubble;
    illegal  = rd && wr;
    tmo      = !illegal && TMO_EN && (waits >= TMO);
    expStall = illegal ? 1 : (tmo ? TMO + 1 : waits + 2);
    expReq   = illegal ? 0 : (tmo ? TMO : waits + 1);
    finished = 1'b0; stallCnt = 0; reqCnt = 0; badReq = 0; badBubble = 0;

    memReadIn = rd; memWriteIn = wr; aluIn = addr; rd2In = data; dmem_ack = 1'b0;
    if (inDone) @(negedge clk);
    else #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (memWbBubble !== stall) badBubble++;
      if (stall === 1'b0) begin
        finished = 1'b1;
        break;
      end
      stallCnt++;
      if (dmem_req === 1'b1) begin
        reqCnt++;
        if (dmem_we !== wr || dmem_addr !== addr || dmem_wdata !== data) badReq++;
        if (reqCnt == waits + 1) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
    end

    if (illegal || tmo) begin
      mRdata = ERR_VAL;
      if (!mBusErr) begin
        mBusErr  = 1'b1;
        mErrAddr = addr;
      end
    end else if (rd) begin
      mRdata = rdata;
    end

    check("acc_finished",  {31'd0, finished}, 32'd1);
    check("acc_stallCnt",  stallCnt,  expStall);
    check("acc_reqCnt",    reqCnt,    expReq);
    check("acc_reqFields", badReq,    32'd0);
    check("acc_bubble",    badBubble, 32'd0);
    check("done_req",      {31'd0, dmem_req},    32'd0);
    check("done_bubble",   {31'd0, memWbBubble}, 32'd0);
    check("done_rdata",    rdataOut, mRdata);
    check("done_busErr",   {31'd0, busErr}, {31'd0, mBusErr});
    check("done_errAddr",  errAddr, mErrAddr);
    inDone = 1'b1;
  endtask

  initial begin
    applyReset();

    doAccess(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hCAFE_F00D);
    idle(1);
    doAccess(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 3, 32'hFFFF_FFFF);
    idle(2);
    doAccess(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h1111_2222);
    doAccess(1'b1, 1'b0, 32'h0000_0108, 32'h0, 0, 32'h3333_4444);
    idle(1);
    doAccess(1'b1, 1'b1, 32'h0000_0400, 32'h0, 0, 32'h0);
    doAccess(1'b1, 1'b1, 32'h0000_0404, 32'h0, 0, 32'h0);
    idle(1);

    // reset during the second REQ cycle, then a stray ack
    memReadIn = 1'b1; aluIn = 32'h0000_0500; #1;
    @(negedge clk);
    check("midrst_req1", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0; memReadIn = 1'b0;
    @(negedge clk);
    check("midrst_req",    {31'd0, dmem_req}, 32'd0);
    check("midrst_stall",  {31'd0, stall},    32'd0);
    check("midrst_busErr", {31'd0, busErr},   32'd0);
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("lateack_req",   {31'd0, dmem_req}, 32'd0);
    check("lateack_stall", {31'd0, stall},    32'd0);
    check("lateack_rdata", rdataOut, 32'd0);
    mRdata = '0; mBusErr = 1'b0; mErrAddr = '0; inDone = 1'b0;

`ifdef MEM_TIMEOUT_EN
    doAccess(1'b1, 1'b0, 32'h0000_0300, 32'h0, 50, 32'hBAD0_BAD0);
    idle(1);
    doAccess(1'b1, 1'b0, 32'h0000_0304, 32'h0, TMO - 1, 32'h7777_8888);
    idle(1);
    applyReset();
`endif

    for (int t = 0; t < 40; t++) begin
      int unsigned kind, waits;
      kind  = $urandom_range(0, 9);
      waits = TMO_EN ? $urandom_range(0, 6) : $urandom_range(0, 5);
      doAccess(kind == 0 || kind >= 6, kind <= 5, $urandom, $urandom, waits, $urandom);
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
